// File: rtl/sub_bytes_pipe.sv
// Pipelined per-lane AES SubBytes with valid/ready handshake and output beat counter.
// Optional inverse S-box selectable per beat when SUB_BYTES_INV_SBOX_EN is defined.
module sub_bytes_pipe #(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv,
    output logic [15:0]          beat_cnt
);

    // Table entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_FWD[idx +: 8];
    endfunction

`ifdef SUB_BYTES_INV_SBOX_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_INV[idx +: 8];
    endfunction
`endif

    logic [8*LANES-1:0] sub_data;
    logic               sub_inv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef SUB_BYTES_INV_SBOX_EN
        assign sub_data[8*i +: 8] = in_inv ? sbox_inv(in_data[8*i +: 8])
                                           : sbox_fwd(in_data[8*i +: 8]);
`else
        assign sub_data[8*i +: 8] = sbox_fwd(in_data[8*i +: 8]);
`endif
    end

`ifdef SUB_BYTES_INV_SBOX_EN
    assign sub_inv = in_inv;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign sub_inv    = 1'b0;
`endif

    // Held low through reset and released by the first clock edge afterwards,
    // so in_ready cannot rise asynchronously with rst_n deassertion.
    logic ready_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    logic               s1_valid;
    logic [8*LANES-1:0] s1_data;
    logic               s1_inv;
    logic               s1_adv;
    logic               s1_load;
    logic               in_fire;

    assign s1_load  = !s1_valid || s1_adv;
    assign in_ready = ready_en && s1_load;
    assign in_fire  = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of its upstream neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_inv   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_data <= sub_data;
                s1_inv  <= sub_inv;
            end
        end
    end

    if (PIPE_STAGES == 2) begin : g_two
        logic               s2_valid;
        logic [8*LANES-1:0] s2_data;
        logic               s2_inv;
        logic               s2_load;

        assign s2_load = !s2_valid || out_ready;
        assign s1_adv  = s1_valid && s2_load;

        // Data only moves with a real beat, so an empty output keeps its last value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
                s2_inv   <= 1'b0;
            end else if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                    s2_inv  <= s1_inv;
                end
            end
        end

        assign out_valid = s2_valid;
        assign out_data  = s2_data;
        assign out_inv   = s2_inv;
    end else begin : g_one
        assign s1_adv    = s1_valid && out_ready;
        assign out_valid = s1_valid;
        assign out_data  = s1_data;
        assign out_inv   = s1_inv;
    end

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_valid && out_ready) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign beat_cnt = cnt;

endmodule
